// File: rtl/bcd_7seg_scan_if.sv
// Digit-load and display-drive bundle for the 3-digit scanned 7-segment driver.
// master: the producer of BCD digits that also observes the display pins.
// slave : the scan driver itself.
interface bcd_7seg_scan_if;
    logic       load;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_done;

    modport master (
        output load, hundreds, tens, ones,
        input  seg, an, frame_done
    );

    modport slave (
        input  load, hundreds, tens, ones,
        output seg, an, frame_done
    );
endinterface

// File: rtl/bcd_7seg_scan.sv
// 3-digit common-anode 7-segment scan driver.
// Digits are captured into a staged register on load and copied into the
// displayed (shadow) register only at frame boundaries, so a frame never
// mixes old and new digits. Each digit is driven for REFRESH_DIV cycles and
// followed by BLANK_CYCLES cycles with every anode off to prevent ghosting.
// Optional: define BCD_7SEG_LEADING_ZERO_BLANK_EN to blank leading zeros
// in the hundreds and tens positions (anodes still pulse, segments dark).
module bcd_7seg_scan #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_7seg_scan_if.slave  bus
);
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [6:0]       SEG_OFF    = 7'h7F;
    localparam logic [2:0]       AN_OFF     = 3'b111;

    typedef enum logic [1:0] {
        RST_IDLE = 2'd0,
        DRIVE    = 2'd1,
        GAP      = 2'd2
    } state_t;

    state_t           state_reg;
    logic [1:0]       digit_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [11:0]      staged_reg;
    logic [11:0]      shadow_reg;
    logic             pending_reg;
    logic [6:0]       seg_reg;
    logic [2:0]       an_reg;
    logic             frame_done_reg;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal codes show a dash.
    function automatic logic [6:0] encode(input logic [3:0] nib);
        case (nib)
            4'd0:    encode = 7'b1000000;
            4'd1:    encode = 7'b1111001;
            4'd2:    encode = 7'b0100100;
            4'd3:    encode = 7'b0110000;
            4'd4:    encode = 7'b0011001;
            4'd5:    encode = 7'b0010010;
            4'd6:    encode = 7'b0000010;
            4'd7:    encode = 7'b1111000;
            4'd8:    encode = 7'b0000000;
            4'd9:    encode = 7'b0010000;
            default: encode = 7'b0111111;
        endcase
    endfunction

    // Segment pattern for digit position d (0=ones,1=tens,2=hundreds) of value v.
    function automatic logic [6:0] seg_for(input logic [1:0] d, input logic [11:0] v);
        logic [3:0] nib;
        logic       blank;
        nib   = (d == 2'd2) ? v[11:8] : (d == 2'd1) ? v[7:4] : v[3:0];
        blank = 1'b0;
`ifdef BCD_7SEG_LEADING_ZERO_BLANK_EN
        if (d == 2'd2 && v[11:8] == 4'd0)
            blank = 1'b1;
        if (d == 2'd1 && v[11:8] == 4'd0 && v[7:4] == 4'd0)
            blank = 1'b1;
`endif
        return blank ? SEG_OFF : encode(nib);
    endfunction

    // One-hot active-low anode for digit position d.
    function automatic logic [2:0] anode_for(input logic [1:0] d);
        return ~(3'b001 << d);
    endfunction

    // Scan FSM, staged/shadow digit registers and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= RST_IDLE;
            digit_reg      <= 2'd0;
            cnt_reg        <= '0;
            staged_reg     <= 12'h000;
            shadow_reg     <= 12'h000;
            pending_reg    <= 1'b0;
            seg_reg        <= SEG_OFF;
            an_reg         <= AN_OFF;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                RST_IDLE: begin
                    state_reg <= DRIVE;
                    digit_reg <= 2'd0;
                    cnt_reg   <= '0;
                    an_reg    <= anode_for(2'd0);
                    seg_reg   <= seg_for(2'd0, shadow_reg);
                end
                DRIVE: begin
                    if (cnt_reg == DRIVE_LAST) begin
                        state_reg <= GAP;
                        cnt_reg   <= '0;
                        an_reg    <= AN_OFF;
                        seg_reg   <= SEG_OFF;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        state_reg <= DRIVE;
                        cnt_reg   <= '0;
                        if (digit_reg == 2'd2) begin
                            // Frame boundary: commit the staged value (as it was
                            // before this edge) so the new frame shows it from
                            // its very first cycle.
                            digit_reg      <= 2'd0;
                            an_reg         <= anode_for(2'd0);
                            frame_done_reg <= 1'b1;
                            if (pending_reg) begin
                                shadow_reg  <= staged_reg;
                                pending_reg <= 1'b0;
                                seg_reg     <= seg_for(2'd0, staged_reg);
                            end else begin
                                seg_reg     <= seg_for(2'd0, shadow_reg);
                            end
                        end else begin
                            digit_reg <= digit_reg + 2'd1;
                            an_reg    <= anode_for(digit_reg + 2'd1);
                            seg_reg   <= seg_for(digit_reg + 2'd1, shadow_reg);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= RST_IDLE;
                    an_reg    <= AN_OFF;
                    seg_reg   <= SEG_OFF;
                end
            endcase
            // A load on a boundary edge lands here after the commit above, so
            // it stays pending for the next frame.
            if (bus.load) begin
                staged_reg  <= {bus.hundreds, bus.tens, bus.ones};
                pending_reg <= 1'b1;
            end
        end
    end

    assign bus.seg        = seg_reg;
    assign bus.an         = an_reg;
    assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Self-checking bench for bcd_7seg_scan (REFRESH_DIV=4, BLANK_CYCLES=2).
// Expected display is derived from the edge count since reset release and
// the digit value shown in each frame; table vectors pin exact segment codes.
module tb_bcd_7seg_scan;
    localparam int RD    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = RD + BC;
    localparam int FRAME = 3 * SLOT;

`ifdef BCD_7SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZB = 7'h7F;
    localparam bit LZB = 1'b1;
`else
    localparam logic [6:0] ZB = 7'h40;
    localparam bit LZB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_7seg_scan_if bus ();

    bcd_7seg_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] enc_tab [16];

    // Reference state: edges since release, staged/pending/shown digits.
    int          k;
    logic [11:0] m_staged;
    logic [11:0] m_shown;
    bit          m_pending;

    typedef struct {
        logic [3:0] h, t, o;
        logic [6:0] sh, st, so;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int slot, input logic [11:0] v);
        logic [3:0] nib;
        nib = v[4*slot +: 4];
        if (LZB && slot == 2 && v[11:8] == 4'd0) return 7'h7F;
        if (LZB && slot == 1 && v[11:4] == 8'd0) return 7'h7F;
        return enc_tab[nib];
    endfunction

    task automatic model_reset();
        k = 0;
        m_staged = 12'h000;
        m_shown = 12'h000;
        m_pending = 1'b0;
    endtask

    // Advance the reference by one clock edge using the inputs currently applied.
    task automatic model_edge();
        k++;
        if (k > 1 && (k - 1) % FRAME == 0 && m_pending) begin
            m_shown = m_staged;
            m_pending = 1'b0;
        end
        if (bus.load) begin
            m_staged = {bus.hundreds, bus.tens, bus.ones};
            m_pending = 1'b1;
        end
    endtask

    task automatic check_model();
        int p, slot, q;
        logic [2:0] ean;
        logic [6:0] eseg;
        p = (k - 1) % FRAME;
        slot = p / SLOT;
        q = p % SLOT;
        ean = 3'b111;
        eseg = 7'h7F;
        if (q < RD) begin
            ean = ~(3'b001 << slot);
            eseg = ref_seg(slot, m_shown);
        end
        check("model_an", 32'(bus.an), 32'(ean));
        check("model_seg", 32'(bus.seg), 32'(eseg));
        check("model_fd", 32'(bus.frame_done), 32'(k > 1 && p == 0));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        bus.load = 1'b1;
        bus.hundreds = h;
        bus.tens = t;
        bus.ones = o;
        step();
        bus.load = 1'b0;
    endtask

    task automatic wait_fd(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = bus.frame_done;
        end
        check("frame_done_seen", 32'(seen), 32'd1);
    endtask

    // Walk one full frame starting at its first cycle, against fixed codes.
    task automatic check_frame(input logic [6:0] sh, input logic [6:0] st, input logic [6:0] so,
                               input bit fd_exp);
        logic [6:0] codes [3];
        codes[0] = so;
        codes[1] = st;
        codes[2] = sh;
        check("frame_start_fd", 32'(bus.frame_done), 32'(fd_exp));
        for (int p = 0; p < FRAME; p++) begin
            int slot, q;
            if (p > 0) step();
            slot = p / SLOT;
            q = p % SLOT;
            if (q < RD) begin
                check("vec_an", 32'(bus.an), 32'(slot == 0 ? 3'b110 : slot == 1 ? 3'b101 : 3'b011));
                check("vec_seg", 32'(bus.seg), 32'(codes[slot]));
            end else begin
                check("gap_an", 32'(bus.an), 32'(3'b111));
                check("gap_seg", 32'(bus.seg), 32'(7'h7F));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog k=%0d", k);
        $fatal(1, "timeout");
    end

    initial begin
        enc_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        vecs[0] = '{h: 4'd1, t: 4'd2, o: 4'd3, sh: 7'h79, st: 7'h24, so: 7'h30};
        vecs[1] = '{h: 4'd1, t: 4'hC, o: 4'd3, sh: 7'h79, st: 7'h3F, so: 7'h30};
        vecs[2] = '{h: 4'd0, t: 4'd0, o: 4'd5, sh: ZB,    st: ZB,    so: 7'h12};
        vecs[3] = '{h: 4'd0, t: 4'd5, o: 4'd0, sh: ZB,    st: 7'h12, so: 7'h40};
        vecs[4] = '{h: 4'd9, t: 4'd8, o: 4'd7, sh: 7'h10, st: 7'h00, so: 7'h78};
        vecs[5] = '{h: 4'hF, t: 4'd0, o: 4'd6, sh: 7'h3F, st: 7'h40, so: 7'h02};
        vecs[6] = '{h: 4'd0, t: 4'hC, o: 4'd9, sh: ZB,    st: 7'h3F, so: 7'h10};

        // Reset with arbitrary inputs, including a load strobe that must be ignored.
        bus.load = 1'b1;
        bus.hundreds = 4'd7;
        bus.tens = 4'd7;
        bus.ones = 4'd7;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_an", 32'(bus.an), 32'(3'b111));
        check("rst_seg", 32'(bus.seg), 32'(7'h7F));
        check("rst_fd", 32'(bus.frame_done), 32'd0);
        bus.load = 1'b0;
        rst_n = 1'b1;
        step();
        check("first_an", 32'(bus.an), 32'(3'b110));
        check("first_seg", 32'(bus.seg), 32'(7'h40));

        // Table vectors: each load shows up in the frame after the next boundary.
        for (int i = 0; i < 7; i++) begin
            do_load(vecs[i].h, vecs[i].t, vecs[i].o);
            wait_fd(2 * FRAME);
            check_frame(vecs[i].sh, vecs[i].st, vecs[i].so, 1'b1);
        end

        // Two loads within one frame: only the later one is ever displayed.
        step();
        do_load(4'd4, 4'd5, 4'd6);
        step();
        do_load(4'd7, 4'd8, 4'd9);
        wait_fd(2 * FRAME);
        check_frame(7'h78, 7'h00, 7'h10, 1'b1);

        // Load on the boundary edge with another value already pending.
        step();
        do_load(4'd2, 4'd4, 4'd6);
        for (int i = 0; i < 2 * FRAME && (k - 1) % FRAME != FRAME - 1; i++) step();
        do_load(4'd3, 4'd5, 4'd7);
        check_frame(7'h24, 7'h19, 7'h02, 1'b1);
        step();
        check_frame(7'h30, 7'h12, 7'h78, 1'b1);

        // Show 123, then reset asynchronously while the tens digit is driven.
        do_load(4'd1, 4'd2, 4'd3);
        wait_fd(2 * FRAME);
        for (int i = 0; i < FRAME && (k - 1) % FRAME != SLOT + 1; i++) step();
        check("pre_rst_an", 32'(bus.an), 32'(3'b101));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_an", 32'(bus.an), 32'(3'b111));
        check("async_rst_seg", 32'(bus.seg), 32'(7'h7F));
        check("async_rst_fd", 32'(bus.frame_done), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_frame(ZB, ZB, 7'h40, 1'b0);

        // Randomized loads at random times, checked against the reference.
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = int'($urandom_range(0, 25));
            for (int i = 0; i < gap; i++) step();
            do_load(4'($urandom), 4'($urandom), 4'($urandom));
        end
        repeat (2 * FRAME) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
